// File: rtl/mdu_div_seq_if.sv
// Handshake/bus bundle between the EX-stage caller and the sequential divider.
interface mdu_div_seq_if #(
  parameter int WIDTH = 32
);
  logic                 abort;
  logic [1:0]           div_op;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic [2*WIDTH-1:0]   result;
  logic                 done;

  // Caller side: issues ops and flushes, watches done/result.
  modport master (
    output abort, div_op, dividend, divisor,
    input  result, done
  );

  // Divider side.
  modport slave (
    input  abort, div_op, dividend, divisor,
    output result, done
  );
endinterface

// File: rtl/mdu_div_seq.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX-stage multi-cycle unit.
// Divides magnitudes one quotient bit per cycle, fixes signs in a final cycle and
// commits {remainder, quotient} to result in the same edge that raises done.
module mdu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  mdu_div_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd;      // shifts left; quotient bits enter at the LSB
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic               q_neg;
  logic               r_neg;
  logic               dz;       // divide by zero latched at start
  logic               done_q;
  logic               done_d;   // done one cycle ago: a start needs done stable high
  logic [2*WIDTH-1:0] result_q;

  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH+1:0]   trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Start decode, operand magnitudes, one restoring step and the final sign fix.
  always_comb begin
    sgn   = (bus.div_op == 2'b10);
    start = (state == S_IDLE) && done_d && !bus.abort &&
            ((bus.div_op == 2'b10) || (bus.div_op == 2'b01));
    a_mag = (sgn && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    b_mag = (sgn && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    // {rem, next dividend bit} is WIDTH+1 bits; the extra top bit is the borrow,
    // so a 0x80000000 magnitude divisor cannot overflow the compare.
    trial    = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dvs};
    q_bit    = ~trial[WIDTH+1];
    // On restore the shifted remainder is below dvs, so it still fits WIDTH bits.
    rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    // Divide by zero: every step subtracts 0, so the quotient ends all ones and
    // rem ends as |dividend|; re-applying the dividend sign yields the raw dividend.
    quo_fix  = dz ? '1 : (q_neg ? -dvd : dvd);
    rem_fix  = r_neg ? -rem : rem;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      done_q   <= 1'b1;
      done_d   <= 1'b1;
      result_q <= '0;
    end else begin
      done_d <= done_q;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            q_neg  <= sgn && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg  <= sgn && bus.dividend[WIDTH-1];
            dz     <= (bus.divisor == '0);
            cnt    <= '0;
            done_q <= 1'b0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.abort) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            rem <= rem_next;
            dvd <= {dvd[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          // An aborted divide leaves the previous result in place.
          if (!bus.abort) result_q <= {rem_fix, quo_fix};
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq: directed corners plus randomized divides
// against an arithmetic reference model.
module tb_mdu_div_seq;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mdu_div_seq_if #(.WIDTH(32)) bus();
  mdu_div_seq #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic [63:0] last_res = '0;

  always @(posedge bus.done) rises++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = int'(a);
    sb = int'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // kind: 0 none, 1 extra div_op at cycle inj, 2 abort at cycle inj.
  task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj, input int kind);
    int lat;
    int r0;
    logic changed;
    logic [63:0] exp_res;
    exp_res = (kind == 2) ? last_res : model(op == 2'b10, a, b);
    r0 = rises;
    changed = 1'b0;
    @(negedge clk);
    bus.div_op = op; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.div_op = 2'b00;
    lat = 0;
    while (bus.done == 1'b0 && lat < 100) begin
      if (bus.result !== last_res) changed = 1'b1;
      lat++;
      if (lat == inj) begin
        if (kind == 1) begin
          bus.div_op = 2'b10; bus.dividend = $urandom; bus.divisor = 32'd1;
        end else if (kind == 2) begin
          bus.abort = 1'b1;
        end
      end
      @(negedge clk);
      bus.div_op = 2'b00;
      bus.abort  = 1'b0;
    end
    check({tag, ".lat"}, 64'(lat), (kind == 2) ? 64'(inj) : 64'd33);
    check({tag, ".res"}, bus.result, exp_res);
    check({tag, ".mid"}, 64'(changed), 64'd0);
    check({tag, ".rise"}, 64'(rises - r0), 64'd1);
    last_res = exp_res;
  endtask

  initial begin
    bus.abort = 1'b0; bus.div_op = 2'b00; bus.dividend = '0; bus.divisor = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.done", 64'(bus.done), 64'd1);
    check("rst.res", bus.result, 64'd0);
    resetn = 1'b1;

    run_div("u100_7", 2'b01, 32'd100, 32'd7, 0, 0);
    run_div("s-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_div("s7_-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_div("u_dz", 2'b01, 32'h1234, 32'd0, 0, 0);
    run_div("s_dz", 2'b10, 32'h1234, 32'd0, 0, 0);
    run_div("s_dzneg", 2'b10, 32'hFFFF_FF00, 32'd0, 0, 0);
    run_div("s_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div("u_max1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_div("s_minmin", 2'b10, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_div("u_bigdiv", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);

    // A start in the very cycle done rises must be ignored.
    bus.div_op = 2'b01; bus.dividend = 32'd9; bus.divisor = 32'd2;
    @(negedge clk);
    bus.div_op = 2'b00;
    check("rise_start_ign", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("rise_start_ign2", 64'(bus.done), 64'd1);

    // Abort together with a start in IDLE suppresses the start.
    bus.abort = 1'b1; bus.div_op = 2'b10;
    @(negedge clk);
    bus.abort = 1'b0; bus.div_op = 2'b00;
    check("abort_start_ign", 64'(bus.done), 64'd1);

    run_div("busy_ign", 2'b01, 32'd1000, 32'd3, 10, 1);
    run_div("abort20", 2'b10, 32'hFFFF_FFCE, 32'd7, 20, 2);
    run_div("after_abort", 2'b10, 32'hFFFF_FFCE, 32'd7, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), op, a, b, 0, 0);
    end

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    bus.div_op = 2'b01; bus.dividend = 32'd12345; bus.divisor = 32'd11;
    @(negedge clk);
    bus.div_op = 2'b00;
    check("mid.busy", 64'(bus.done), 64'd0);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst.done", 64'(bus.done), 64'd1);
    check("mid_rst.res", bus.result, 64'd0);
    last_res = '0;
    @(negedge clk);
    resetn = 1'b1;

    run_div("post_rst", 2'b01, 32'd100, 32'd7, 0, 0);
    run_div("b2b", 2'b10, 32'h8000_0000, 32'd3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
